// File: rtl/riscv_icu_launcher.sv
// riscv_icu_launcher: EX-stage issue/stall control for the multi-cycle
// multiplier, with flush drain and a watchdog against a hung unit.
module riscv_icu_launcher #(
  parameter int XLEN     = 64,
  parameter int MAX_WAIT = 64
) (
  input  logic            i_riscv_launch_clk,
  input  logic            i_riscv_launch_rst,
  input  logic            i_riscv_launch_req_valid,
  input  logic [1:0]      i_riscv_launch_funcsel,
  input  logic            i_riscv_launch_flush,
  input  logic            i_riscv_launch_unit_valid,
  input  logic [XLEN-1:0] i_riscv_launch_unit_result,
  output logic            o_riscv_launch_unit_start,
  output logic            o_riscv_launch_stall,
  output logic [XLEN-1:0] o_riscv_launch_result,
  output logic            o_riscv_launch_result_valid,
  output logic            o_riscv_launch_timeout
);

  localparam int CW = $clog2(MAX_WAIT) + 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE,
    DRAIN
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic          is_mul;
  logic          launch;
  logic          limit;

  assign is_mul  = i_riscv_launch_req_valid &
                   (i_riscv_launch_funcsel == 2'b00);
  assign launch  = is_mul & ~i_riscv_launch_flush;
  assign cnt_inc = cnt + CW'(1);
  // >= so a flush taken on the limit cycle still times out in DRAIN
  assign limit   = cnt_inc >= CW'(MAX_WAIT - 1);

  always_comb begin
    o_riscv_launch_unit_start   = 1'b0;
    o_riscv_launch_stall        = 1'b0;
    o_riscv_launch_result_valid = 1'b0;
    unique case (state)
      IDLE: begin
        o_riscv_launch_unit_start = launch;
        o_riscv_launch_stall      = launch;
      end
      BUSY:  o_riscv_launch_stall        = 1'b1;
      DONE:  o_riscv_launch_result_valid = 1'b1;
      DRAIN: o_riscv_launch_stall        = is_mul;
      default: ;
    endcase
    if (i_riscv_launch_rst) begin
      o_riscv_launch_unit_start   = 1'b0;
      o_riscv_launch_stall        = 1'b0;
      o_riscv_launch_result_valid = 1'b0;
    end
  end

  always_ff @(posedge i_riscv_launch_clk or posedge i_riscv_launch_rst) begin
    if (i_riscv_launch_rst) begin
      state                  <= IDLE;
      cnt                    <= '0;
      o_riscv_launch_result  <= '0;
      o_riscv_launch_timeout <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (launch) begin
            cnt   <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          cnt <= cnt_inc;
          if (i_riscv_launch_flush) begin
            state <= i_riscv_launch_unit_valid ? IDLE : DRAIN;
          end else if (i_riscv_launch_unit_valid) begin
            o_riscv_launch_result <= i_riscv_launch_unit_result;
            state                 <= DONE;
          end else if (limit) begin
            o_riscv_launch_timeout <= 1'b1;
            o_riscv_launch_result  <= '0;
            state                  <= DONE;
          end
        end
        DONE: state <= IDLE;
        DRAIN: begin
          cnt <= cnt_inc;
          if (i_riscv_launch_unit_valid) begin
            state <= IDLE;
          end else if (limit) begin
            o_riscv_launch_timeout <= 1'b1;
            state                  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
